// File: rtl/ucsbece154b_wide_fifo.sv
// ucsbece154b_wide_fifo: two-lane circular-buffer FIFO.
// Up to two entries may be pushed and up to two popped per cycle.
// Optional feature macro UCSBECE154B_FIFO_BYPASS_EN: when the FIFO is empty,
// accepted push lanes are forwarded combinationally to data_o/valid_o.
// Without the macro, outputs depend only on registered state.
//
// Handshake: a push of push_n entries is accepted all-or-nothing when
// push_n fits in the free space at the start of the cycle. No ready signal
// is returned; space_o tells the producer in advance whether 1 or 2 entries fit.
// A pop on lane k consumes the entry shown on data_o lane k. The pop takes
// effect only if valid_o[k] is set in that same cycle.
module ucsbece154b_wide_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int NR_ENTRIES = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic [1:0]                        push_i,
    input  logic [2*DATA_WIDTH-1:0]           data_i,
    input  logic [1:0]                        pop_i,
    output logic [2*DATA_WIDTH-1:0]           data_o,
    output logic [1:0]                        valid_o,
    output logic [1:0]                        space_o,
    output logic [$clog2(NR_ENTRIES+1)-1:0]   count_o,
    output logic                              full_o,
    output logic                              almost_full_o
);

    localparam int CW = $clog2(NR_ENTRIES + 1);
    localparam int PW = $clog2(NR_ENTRIES);
    localparam logic [CW-1:0] DEPTH_C = CW'(NR_ENTRIES);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    // Storage is deliberately left unreset; entries are only visible while valid.
    logic [DATA_WIDTH-1:0] mem_q [NR_ENTRIES];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [DATA_WIDTH-1:0] lane_in [2];
    logic [1:0]            push_n;
    logic [1:0]            pop_n;
    logic [CW-1:0]         free_n;
    logic                  push_ok;
    logic [1:0]            acc_n;
    logic [1:0]            avail_n;
    logic [1:0]            pop_eff;
    logic [1:0]            wr_n;
    logic                  wr_first_lane;
    logic                  wr_en0;
    logic                  wr_en1;
    logic [PW-1:0]         tail1;
    logic [PW-1:0]         head1;
    logic                  byp_active;

    // Advance a pointer by 0..2 with wrap modulo NR_ENTRIES (depth need not be 2^n).
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(n);
        if (s >= (PW+1)'(NR_ENTRIES)) begin
            s = s - (PW+1)'(NR_ENTRIES);
        end
        return s[PW-1:0];
    endfunction

    assign lane_in[0] = data_i[0 +: DATA_WIDTH];
    assign lane_in[1] = data_i[DATA_WIDTH +: DATA_WIDTH];
    assign tail1      = ptr_add(tail_q, 2'd1);
    assign head1      = ptr_add(head_q, 2'd1);

`ifdef UCSBECE154B_FIFO_BYPASS_EN
    // The empty FIFO forwards this cycle's accepted pushes straight to the outputs.
    assign byp_active = (count_q == '0) && !flush_i && !rst;
`else
    assign byp_active = 1'b0;
`endif

    // Decode request counts, acceptance, effective pops and the write plan.
    always_comb begin
        // Lane 1 counts only together with lane 0, so 2'b10 decodes to zero.
        push_n  = {push_i[0] & push_i[1], push_i[0] & ~push_i[1]};
        pop_n   = {pop_i[0] & pop_i[1], pop_i[0] & ~pop_i[1]};
        free_n  = DEPTH_C - count_q;
        // Pre-pop occupancy decides acceptance; same-cycle pops free no space.
        push_ok = (CW'(push_n) <= free_n);
        acc_n   = push_ok ? push_n : 2'd0;
        if (byp_active) begin
            avail_n = acc_n;
        end else if (count_q >= CW'(2)) begin
            avail_n = 2'd2;
        end else begin
            avail_n = count_q[1:0];
        end
        pop_eff = (pop_n < avail_n) ? pop_n : avail_n;
        // Under bypass, popped lanes are consumed in flight and never stored.
        wr_n          = byp_active ? (acc_n - pop_eff) : acc_n;
        wr_first_lane = byp_active && (pop_eff == 2'd1);
        wr_en0        = !rst && !flush_i && (wr_n != 2'd0);
        wr_en1        = !rst && !flush_i && (wr_n == 2'd2);
    end

    // Next-state for the pointers and occupancy; reset beats flush beats traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst || flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (!byp_active) begin
                head_d = ptr_add(head_q, pop_eff);
            end
            tail_d  = ptr_add(tail_q, wr_n);
            count_d = count_q + CW'(acc_n) - CW'(pop_eff);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    // Storage writes: first stored lane at tail, second at tail+1.
    always_ff @(posedge clk) begin
        if (wr_en0) begin
            mem_q[tail_q] <= lane_in[wr_first_lane];
        end
        if (wr_en1) begin
            mem_q[tail1] <= lane_in[1];
        end
    end

    // Read side: the two oldest entries, zeroed when not valid.
    always_comb begin
        valid_o = {count_q > CW'(1), count_q != '0};
        data_o  = '0;
        if (valid_o[0]) begin
            data_o[0 +: DATA_WIDTH] = mem_q[head_q];
        end
        if (valid_o[1]) begin
            data_o[DATA_WIDTH +: DATA_WIDTH] = mem_q[head1];
        end
`ifdef UCSBECE154B_FIFO_BYPASS_EN
        if (byp_active) begin
            valid_o = {acc_n == 2'd2, acc_n != 2'd0};
            data_o  = '0;
            if (valid_o[0]) begin
                data_o[0 +: DATA_WIDTH] = lane_in[0];
            end
            if (valid_o[1]) begin
                data_o[DATA_WIDTH +: DATA_WIDTH] = lane_in[1];
            end
        end
`endif
    end

    assign count_o       = count_q;
    assign full_o        = (count_q == DEPTH_C);
    assign almost_full_o = (count_q >= AF_C);
    assign space_o[0]    = (count_q < DEPTH_C);
    assign space_o[1]    = (({1'b0, count_q} + (CW+1)'(2)) <= (CW+1)'(NR_ENTRIES));

endmodule

// File: doc/ucsbece154b_wide_fifo.md
UCSBECE154B_WIDE_FIFO -- requirements
Module: ucsbece154b_wide_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of one entry.
REQ-002 SHALL have parameter NR_ENTRIES, default 8, depth in entries; legal range 2..64, power of two not required.
REQ-003 SHALL have parameter AF_THRESH, default 6, almost-full level; legal range 1..NR_ENTRIES.
REQ-004 SHALL have port clk input 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst input 1, reset, synchronous, active-high.
REQ-006 SHALL have port flush_i input 1, discard all stored entries.
REQ-007 SHALL have port push_i input 2, per-lane push request; lane 1 is meaningful only with lane 0.
REQ-008 SHALL have port data_i input 2*DATA_WIDTH, lane k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port pop_i input 2, per-lane pop request; lane 1 is meaningful only with lane 0.
REQ-010 SHALL have port data_o output 2*DATA_WIDTH, lane 0 = oldest entry, lane 1 = second oldest.
REQ-011 SHALL have port valid_o output 2, per-lane data_o validity.
REQ-012 SHALL have port space_o output 2, bit 0 = at least 1 free entry, bit 1 = at least 2 free entries.
REQ-013 SHALL have port count_o output $clog2(NR_ENTRIES+1), number of stored entries.
REQ-014 SHALL have port full_o output 1, count_o == NR_ENTRIES.
REQ-015 SHALL have port almost_full_o output 1, count_o >= AF_THRESH.

Function
REQ-016 SHALL store entries in a circular buffer with head and tail pointers; each pointer wraps from NR_ENTRIES-1 to 0, and a +2 step wraps modulo NR_ENTRIES.
REQ-017 SHALL decode requests as counts: push_n = push_i[0] + (push_i[0] & push_i[1]), pop_n = pop_i[0] + (pop_i[0] & pop_i[1]); push_i/pop_i = 2'b10 count as 0.
REQ-018 SHALL accept a push all-or-nothing: accepted iff push_n <= free entries at the start of the cycle; otherwise no lane is written.
REQ-019 SHALL check push space against pre-pop occupancy; space freed by a same-cycle pop is not reused.
REQ-020 SHALL write accepted lane 0 at tail and lane 1 at tail+1, then advance tail by push_n.
REQ-021 SHALL limit effective pops to min(pop_n, valid lanes); popping an invalid lane has no effect, and head advances by the effective pop count.
REQ-022 SHALL update count as count + accepted pushes - effective pops in one cycle.
REQ-023 SHALL drive valid_o[k] = (count_o > k) and data_o lane k = entry at head+k; an invalid lane drives zero.
REQ-024 SHALL give write-to-read latency of 1 cycle: a word pushed at edge N is visible after edge N.
REQ-025 SHALL, on flush_i, zero head, tail and count at the next edge, ignoring same-cycle push and pop.
REQ-026 SHALL make full_o, almost_full_o, space_o and count_o pure functions of registered state.

Reset
REQ-027 SHALL give rst priority over flush_i, push_i and pop_i.
REQ-028 SHALL, after a reset edge, have head = tail = 0, count_o = 0, valid_o = 0, data_o = 0, space_o = 2'b11, full_o = 0 and almost_full_o = 0.
REQ-029 SHALL not reset the storage array; contents are unobservable while invalid.
REQ-030 SHALL, when rst is asserted mid-stream, discard all stored entries with no further writes.

Configuration
REQ-031 SHALL support macro UCSBECE154B_FIFO_BYPASS_EN.
REQ-032 SHALL, when UCSBECE154B_FIFO_BYPASS_EN is defined and count_o == 0 and flush_i = 0, drive valid_o[k] = accepted push on lane k and data_o lane k = data_i lane k combinationally.
REQ-033 SHALL, under bypass, not store lanes popped in the same cycle; only unpopped accepted lanes are written, from tail in lane order.
REQ-034 SHALL, when UCSBECE154B_FIFO_BYPASS_EN is undefined, produce no combinational path from push_i/data_i to outputs, so that REQ-024 holds unconditionally.

Verification
REQ-035 SHALL cover reset: after rst, count_o = 0, valid_o = 2'b00, space_o = 2'b11 and data_o = 0.
REQ-036 SHALL cover dual push and pop: push 2'b11 of A,B -> next cycle count_o = 2 and lanes = A,B; pop 2'b11 -> count_o = 0.
REQ-037 SHALL cover fill and reject: with NR_ENTRIES = 8, push 7 entries -> space_o = 2'b01; push 2'b11 of X,Y -> rejected, count stays 7 and almost_full_o = 1; push 2'b01 of X -> full_o = 1.
REQ-038 SHALL cover wrap-around: 20 cycles of push 2 / pop 2 with an incrementing pattern -> output order matches input order and count stays 2.
REQ-039 SHALL cover flush: flush_i with count 5 plus same-cycle push 2'b11 -> next cycle count_o = 0, valid_o = 0, and nothing is stored.
REQ-040 SHALL cover bypass: with the macro defined and the FIFO empty, push 2'b11 of C,D plus pop 2'b01 -> same cycle lane 0 = C, valid; next cycle count_o = 1 and lane 0 = D.
